// File: rtl/regfile_wb_32_pkg.sv
// Shared constants and state encoding for the write-back register file.
package regfile_wb_32_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DEPTH      = 32;
  localparam int unsigned REG_ZERO_ADDR  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } reg_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every register address once, then reports ready.
module regfile_clear_ctrl
  import regfile_wb_32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned DEPTH      = REG_DEPTH
) (
  input  logic                  clock_in,
  input  logic                  reset_signal,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  ready
);

  reg_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_ff @(posedge clock_in) begin
    if (reset_signal) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clear_we = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // The reset cycle itself must leave storage untouched.
        clear_we = ~reset_signal;
        idx_d    = idx_q + 1'b1;
        if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clear_addr = idx_q;
  assign ready      = (state_q == READY);

endmodule

// File: rtl/regfile_wb_32.sv
// 32x32 register file fed by the write-back selector; r0 reads as zero.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_wb_32
  import regfile_wb_32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned DEPTH      = REG_DEPTH
) (
  input  logic                  clock_in,
  input  logic                  reset_signal,
  input  logic                  enable_signal,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(REG_ZERO_ADDR);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  user_we;

  regfile_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear_ctrl (
    .clock_in     (clock_in),
    .reset_signal (reset_signal),
    .clear_we     (clear_we),
    .clear_addr   (clear_addr),
    .ready        (ready)
  );

  assign user_we = ready & enable_signal & ~reset_signal & (write_addr != ZeroAddr);

  // No reset on storage: the sweep zeroes it one entry per cycle.
  always_ff @(posedge clock_in) begin
    if (clear_we) begin
      mem_q[clear_addr] <= '0;
    end else if (user_we) begin
      mem_q[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (ready) begin
      if (read_addr1 != ZeroAddr) begin
        read_data1 = mem_q[read_addr1];
`ifdef REGFILE_BYPASS_EN
        if (user_we && (read_addr1 == write_addr)) begin
          read_data1 = write_data;
        end
`endif
      end
      if (read_addr2 != ZeroAddr) begin
        read_data2 = mem_q[read_addr2];
`ifdef REGFILE_BYPASS_EN
        if (user_we && (read_addr2 == write_addr)) begin
          read_data2 = write_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_32.sv
// Directed self-checking bench for regfile_wb_32.
module tb_regfile_wb_32;

  logic        clock_in = 1'b0;
  logic        reset_signal;
  logic        enable_signal;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [6];

  regfile_wb_32 dut (
    .clock_in      (clock_in),
    .reset_signal  (reset_signal),
    .enable_signal (enable_signal),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_addr1    (read_addr1),
    .read_addr2    (read_addr2),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .ready         (ready)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd0,  32'h80000001, 32'h00000000};
    vecs[3] = '{1'b0, 5'd6,  32'hFFFFFFFF, 5'd6,  5'd31, 32'h00000000, 32'h80000001};
    vecs[4] = '{1'b1, 5'd5,  32'h00000042, 5'd5,  5'd3,  32'h00000042, 32'h00000000};
    vecs[5] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd2,  32'h11111111, 32'h00000000};

    reset_signal  = 1'b1;
    enable_signal = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    read_addr1    = 5'd7;
    read_addr2    = 5'd0;

    tick();
    tick();
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rd1", read_data1, 32'd0);
    reset_signal = 1'b0;

    // Initial sweep: ready must rise on exactly the 32nd posedge.
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("sweep1_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i < 32) check("sweep1_rd7", read_data1, 32'd0);
    end
    check("post_sweep_rd7", read_data1, 32'd0);

    // Seed a few low registers so the resweep has something to clear.
    enable_signal = 1'b1;
    write_addr = 5'd2; write_data = 32'h22222222; tick();
    write_addr = 5'd4; write_data = 32'h44444444; tick();
    enable_signal = 1'b0;
    read_addr1 = 5'd2; read_addr2 = 5'd4; #1;
    check("seed_r2", read_data1, 32'h22222222);
    check("seed_r4", read_data2, 32'h44444444);

    // Reset in READY, 10 sweep cycles, then a reset pulse mid-sweep.
    reset_signal = 1'b1; tick();
    check("ready_reset_ready", {31'b0, ready}, 32'd0);
    check("ready_reset_mask", read_data1, 32'd0);
    reset_signal = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midsweep_ready", {31'b0, ready}, 32'd0);
    reset_signal = 1'b1; tick();
    reset_signal = 1'b0;
    // Writes during CLEAR must be dropped.
    enable_signal = 1'b1; write_addr = 5'd3; write_data = 32'h00000001;
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) enable_signal = 1'b0;
      tick();
      check("sweep2_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end
    enable_signal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      read_addr1 = 5'(i); #1;
      check("low_entries_zero", read_data1, 32'd0);
    end
    read_addr1 = 5'd3; #1;
    check("clear_write_dropped", read_data1, 32'd0);

    // Table-driven READY vectors: write, then compare reads after the edge.
    for (int i = 0; i < 6; i++) begin
      enable_signal = vecs[i].we;
      write_addr    = vecs[i].waddr;
      write_data    = vecs[i].wdata;
      read_addr1    = vecs[i].ra1;
      read_addr2    = vecs[i].ra2;
      tick();
      enable_signal = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
    end

    // Read-during-write on r9.
    read_addr1    = 5'd5;
    read_addr2    = 5'd9;
    enable_signal = 1'b1;
    write_addr    = 5'd9;
    write_data    = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", read_data2, 32'hA5A5A5A5);
`else
    check("rdw_before_edge", read_data2, 32'h00000000);
`endif
    check("rdw_other_port", read_data1, 32'h00000042);
    tick();
    enable_signal = 1'b0;
    #1;
    check("rdw_after_edge", read_data2, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
